// File: rtl/disp_page_sched.sv
// disp_page_sched: pages NSRC 32-bit debug sources onto the display,
// advancing on a debounced button or a dwell timer, with req/ack capture.
module disp_page_sched #(
  parameter int NSRC    = 4,
  parameter int PW      = 2,
  parameter int DWELL   = 50_000_000,
  parameter int DB_BITS = 20
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NSRC*32-1:0] src_data_i,
  input  logic [NSRC-1:0]    src_req_i,
  output logic [NSRC-1:0]    src_ack_o,
  input  logic               btn_next_i,
  input  logic               auto_en_i,
  input  logic               freeze_i,
  output logic [31:0]        disp_s_o,
  output logic [PW-1:0]      disp_page_o,
  output logic               page_change_o
);

  localparam int CW = $clog2(DWELL);
  localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
  localparam logic [PW-1:0] PG_LAST = PW'(NSRC - 1);

  localparam logic [1:0] S_SWITCH = 2'd0;
  localparam logic [1:0] S_SHOW   = 2'd1;
  localparam logic [1:0] S_FROZEN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      page_q, page_d;
  logic [31:0]        disp_q, disp_d;
  logic [NSRC-1:0]    ack_q, ack_d;
  logic               pc_q, pc_d;
  logic [CW-1:0]      dwell_q, dwell_d;
  logic [1:0]         sync_q;
  logic               db_q, db_d, db_prev_q;
  logic [DB_BITS-1:0] dbcnt_q, dbcnt_d;

  logic [31:0] cur;
  logic        req_cur;
  logic        adv_btn, adv_auto, adv;

  assign cur     = src_data_i[32*page_q +: 32];
  assign req_cur = src_req_i[page_q];
  assign adv_btn = db_q & ~db_prev_q;

  // Dwell only runs while the page is actually being shown.
  assign adv_auto = (state_q == S_SHOW) && !freeze_i
                  && auto_en_i && (dwell_q == DW_LAST);
  assign adv      = adv_btn | adv_auto;

  always_comb begin
    db_d    = db_q;
    dbcnt_d = dbcnt_q;
    if (sync_q[1] == db_q) begin
      dbcnt_d = '0;
    end else if (&dbcnt_q) begin
      db_d    = sync_q[1];
      dbcnt_d = '0;
    end else begin
      dbcnt_d = dbcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    disp_d  = disp_q;
    ack_d   = '0;
    pc_d    = 1'b0;
    unique case (state_q)
      S_SWITCH: begin
        disp_d  = cur;
        pc_d    = 1'b1;
        state_d = S_SHOW;
        if (req_cur) ack_d = NSRC'(1) << page_q;
      end
      S_SHOW: begin
        if (freeze_i) begin
          state_d = S_FROZEN;
        end else if (adv) begin
          page_d  = (page_q == PG_LAST) ? '0 : page_q + 1'b1;
          state_d = S_SWITCH;
        end else if (req_cur && ~|ack_q) begin
          disp_d = cur;
          ack_d  = NSRC'(1) << page_q;
        end
      end
      S_FROZEN: begin
        if (!freeze_i) state_d = S_SHOW;
      end
      default: state_d = S_SWITCH;
    endcase
  end

  always_comb begin
    dwell_d = dwell_q;
    if (!auto_en_i) begin
      dwell_d = '0;
    end else if (state_q == S_SHOW && !freeze_i) begin
      dwell_d = adv ? '0 : dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_SWITCH;
      page_q    <= '0;
      disp_q    <= '0;
      ack_q     <= '0;
      pc_q      <= 1'b0;
      dwell_q   <= '0;
      sync_q    <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      dbcnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      disp_q    <= disp_d;
      ack_q     <= ack_d;
      pc_q      <= pc_d;
      dwell_q   <= dwell_d;
      sync_q    <= {sync_q[0], btn_next_i};
      db_q      <= db_d;
      db_prev_q <= db_q;
      dbcnt_q   <= dbcnt_d;
    end
  end

  assign src_ack_o     = ack_q;
  assign disp_s_o      = disp_q;
  assign disp_page_o   = page_q;
  assign page_change_o = pc_q;

endmodule

// File: tb/tb_disp_page_sched.sv
// tb_disp_page_sched: scenario tasks plus a page_change scoreboard
// for disp_page_sched with NSRC=4, DWELL=8, DB_BITS=2.
module tb_disp_page_sched;
  localparam int NSRC    = 4;
  localparam int PW      = 2;
  localparam int DWELL   = 8;
  localparam int DB_BITS = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NSRC*32-1:0] src_data;
  logic [NSRC-1:0]    src_req;
  logic [NSRC-1:0]    ack;
  logic               btn, auto_en, freeze;
  logic [31:0]        disp;
  logic [PW-1:0]      page;
  logic               pc;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  disp_page_sched #(
    .NSRC(NSRC), .PW(PW), .DWELL(DWELL), .DB_BITS(DB_BITS)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .src_data_i(src_data),
    .src_req_i(src_req),
    .src_ack_o(ack),
    .btn_next_i(btn),
    .auto_en_i(auto_en),
    .freeze_i(freeze),
    .disp_s_o(disp),
    .disp_page_o(page),
    .page_change_o(pc)
  );

  // Every cycle of the run passes through here: page_change events are
  // popped against the expected queue.
  task automatic tick();
    logic [33:0] e;
    @(negedge clk);
    if (rst_n && pc) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pc_unexpected got page=%0d disp=%h exp none",
                 page, disp);
      end else begin
        e = exp_q.pop_front();
        if ({page, disp} !== e) begin
          errors++;
          $display("FAIL pc_sb got page=%0d disp=%h exp page=%0d disp=%h",
                   page, disp, e[33:32], e[31:0]);
        end
      end
    end
    if (ack !== '0) begin
      checks++;
      if ($countones(ack) != 1) begin
        errors++;
        $display("FAIL ack_onehot got %b exp one bit", ack);
      end
    end
  endtask

  task automatic push_exp(input logic [1:0] p, input logic [31:0] d);
    exp_q.push_back({p, d});
  endtask

  task automatic set_src(input int i, input logic [31:0] v);
    src_data[32*i +: 32] = v;
  endtask

  task automatic wait_pc(input int n, output int cyc, output logic ack_seen);
    cyc = 0;
    ack_seen = 1'b0;
    for (int i = 1; i <= n && cyc == 0; i++) begin
      tick();
      if (pc) cyc = i;
      else if (|ack) ack_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src_req = '0;
    btn = 1'b0;
    auto_en = 1'b0;
    freeze = 1'b0;
    src_data = '0;
    for (int i = 0; i < NSRC; i++) set_src(i, 32'hA000_0000 + i);
    set_src(0, 32'h1234_5678);
    tick();
    tick();
    checks++;
    if (disp !== 32'h0) begin
      errors++; $display("FAIL rst_disp got %h exp 0", disp);
    end
    checks++;
    if (page !== 2'd0) begin
      errors++; $display("FAIL rst_page got %0d exp 0", page);
    end
    checks++;
    if (ack !== 4'b0) begin
      errors++; $display("FAIL rst_ack got %b exp 0", ack);
    end
    checks++;
    if (pc !== 1'b0) begin
      errors++; $display("FAIL rst_pc got %b exp 0", pc);
    end
    push_exp(2'd0, 32'h1234_5678);
    rst_n = 1'b1;
    tick();
    checks++;
    if (pc !== 1'b1) begin
      errors++; $display("FAIL rst_first_pc got %b exp 1", pc);
    end
    tick();
    checks++;
    if (pc !== 1'b0) begin
      errors++; $display("FAIL pc_width got %b exp 0", pc);
    end
  endtask

  task automatic test_auto();
    int cyc;
    logic as;
    push_exp(2'd1, 32'hA000_0001);
    push_exp(2'd2, 32'hA000_0002);
    push_exp(2'd3, 32'hA000_0003);
    push_exp(2'd0, 32'h1234_5678);
    auto_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_pc(12, cyc, as);
      checks++;
      if (cyc != 9) begin
        errors++; $display("FAIL auto_gap%0d got %0d exp 9", k, cyc);
      end
    end
    auto_en = 1'b0;
  endtask

  task automatic test_handshake();
    int cyc;
    logic as;
    set_src(0, 32'hDEAD_BEEF);
    src_req = 4'b0101;
    tick();
    checks++;
    if (disp !== 32'hDEAD_BEEF || ack !== 4'b0001) begin
      errors++;
      $display("FAIL hs_capture got %h/%b exp deadbeef/0001", disp, ack);
    end
    src_req[0] = 1'b0;
    tick();
    checks++;
    if (ack !== 4'b0) begin
      errors++; $display("FAIL hs_ack_len got %b exp 0000", ack);
    end
    tick();
    checks++;
    if (ack !== 4'b0 || disp !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL hs_pending got %b/%h exp 0000/deadbeef", ack, disp);
    end
    push_exp(2'd1, 32'hA000_0001);
    push_exp(2'd2, 32'hA000_0002);
    auto_en = 1'b1;
    wait_pc(12, cyc, as);
    checks++;
    if (cyc != 9 || as !== 1'b0) begin
      errors++; $display("FAIL hs_p1 got gap=%0d ack=%b exp 9/0", cyc, as);
    end
    wait_pc(12, cyc, as);
    checks++;
    if (cyc != 9 || as !== 1'b0) begin
      errors++; $display("FAIL hs_p2 got gap=%0d ack=%b exp 9/0", cyc, as);
    end
    checks++;
    if (ack !== 4'b0100) begin
      errors++; $display("FAIL hs_switch_ack got %b exp 0100", ack);
    end
    auto_en = 1'b0;
    src_req[2] = 1'b0;
    tick();
    checks++;
    if (ack !== 4'b0) begin
      errors++; $display("FAIL hs_switch_ack_len got %b exp 0000", ack);
    end
  endtask

  task automatic test_button();
    int cyc;
    int got;
    logic as;
    btn = 1'b1;
    tick();
    tick();
    btn = 1'b0;
    wait_pc(15, cyc, as);
    checks++;
    if (cyc != 0 || page !== 2'd2) begin
      errors++; $display("FAIL btn_glitch got pc@%0d page=%0d exp none/2", cyc, page);
    end
    push_exp(2'd3, 32'hA000_0003);
    btn = 1'b1;
    got = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (pc && got == 0) got = i;
    end
    btn = 1'b0;
    checks++;
    if (got != 8) begin
      errors++; $display("FAIL btn_latency got %0d exp 8", got);
    end
    wait_pc(15, cyc, as);
    checks++;
    if (cyc != 0 || page !== 2'd3) begin
      errors++; $display("FAIL btn_release got pc@%0d page=%0d exp none/3", cyc, page);
    end
    push_exp(2'd0, 32'hDEAD_BEEF);
    auto_en = 1'b1;
    tick();
    btn = 1'b1;
    wait_pc(12, cyc, as);
    auto_en = 1'b0;
    checks++;
    if (cyc != 8) begin
      errors++; $display("FAIL btn_dwell_coincide got %0d exp 8", cyc);
    end
    repeat (4) tick();
    btn = 1'b0;
    wait_pc(15, cyc, as);
    checks++;
    if (cyc != 0 || page !== 2'd0) begin
      errors++; $display("FAIL btn_single_adv got pc@%0d page=%0d exp none/0", cyc, page);
    end
  endtask

  task automatic test_freeze();
    int cyc;
    int bad;
    logic as;
    auto_en = 1'b1;
    repeat (3) tick();
    set_src(0, 32'hCAFE_F00D);
    src_req = 4'b0001;
    freeze = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (disp !== 32'hDEAD_BEEF || page !== 2'd0 || ack !== 4'b0 || pc !== 1'b0) begin
        errors++;
        if (bad == 0)
          $display("FAIL frz_hold got %h/%0d/%b/%b exp deadbeef/0/0000/0",
                   disp, page, ack, pc);
        bad++;
      end
    end
    freeze = 1'b0;
    push_exp(2'd1, 32'hA000_0001);
    tick();
    checks++;
    if (ack !== 4'b0) begin
      errors++; $display("FAIL frz_exit_ack got %b exp 0000", ack);
    end
    tick();
    checks++;
    if (ack !== 4'b0001 || disp !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL frz_ack got %b/%h exp 0001/cafef00d", ack, disp);
    end
    src_req = '0;
    wait_pc(12, cyc, as);
    auto_en = 1'b0;
    checks++;
    if (cyc != 5) begin
      errors++; $display("FAIL frz_dwell_resume got %0d exp 5", cyc);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic as;
    src_req = 4'b0010;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    tick();
    checks++;
    if (ack !== 4'b0 || page !== 2'd0 || disp !== 32'h0 || pc !== 1'b0) begin
      errors++;
      $display("FAIL rmid_vals got %b/%0d/%h/%b exp 0000/0/0/0", ack, page, disp, pc);
    end
    push_exp(2'd0, 32'hCAFE_F00D);
    rst_n = 1'b1;
    tick();
    checks++;
    if (pc !== 1'b1 || ack !== 4'b0 || page !== 2'd0) begin
      errors++; $display("FAIL rmid_reload got %b/%b/%0d exp 1/0000/0", pc, ack, page);
    end
    push_exp(2'd1, 32'hA000_0001);
    auto_en = 1'b1;
    wait_pc(12, cyc, as);
    auto_en = 1'b0;
    checks++;
    if (cyc != 9 || as !== 1'b0 || ack !== 4'b0010) begin
      errors++;
      $display("FAIL rmid_reserve got gap=%0d early=%b ack=%b exp 9/0/0010", cyc, as, ack);
    end
    src_req = '0;
    tick();
    checks++;
    if (ack !== 4'b0) begin
      errors++; $display("FAIL rmid_ack_len got %b exp 0000", ack);
    end
  endtask

  initial begin
    test_reset();
    test_auto();
    test_handshake();
    test_button();
    test_freeze();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d left exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
